// File: rtl/frame_slot_alloc.sv
// Frame-buffer slot allocator: hands free DDR slots to the writer and queues finished slots.
// Optional statistics counters (drop_cnt, push_cnt) are enabled by defining FRAME_SLOT_STAT_EN.
module frame_slot_alloc #(
    parameter int unsigned SLOT_NUM = 4,
    parameter int unsigned SLOT_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_frame_start,
    input  logic              wr_frame_done,
    output logic [SLOT_W-1:0] wr_slot,
    output logic              wr_slot_vld,
    output logic              wr_drop,
    output logic              fifo_wr_en,
    output logic [SLOT_W-1:0] fifo_wr_data,
    input  logic              fifo_wr_vld,
    input  logic              rel_en,
    input  logic [SLOT_W-1:0] rel_slot,
    output logic [4:0]        free_cnt,
`ifdef FRAME_SLOT_STAT_EN
    output logic [15:0]       drop_cnt,
    output logic [15:0]       push_cnt,
`endif
    output logic              err_rel
);

    typedef enum logic [1:0] {StIdle, StWriting, StPush} state_e;

    localparam logic [SLOT_W:0] SlotLim = (SLOT_W + 1)'(SLOT_NUM);

    state_e              state_q, state_d;
    logic [SLOT_NUM-1:0] free_q, free_d;
    logic [4:0]          free_cnt_q, free_cnt_d;
    logic                pend_q, pend_d;
    logic [SLOT_W-1:0]   wr_slot_q, wr_slot_d;
    logic                wr_slot_vld_q, wr_slot_vld_d;
    logic                wr_drop_q, wr_drop_d;
    logic [SLOT_W-1:0]   fifo_wr_data_q, fifo_wr_data_d;
    logic                err_rel_q, err_rel_d;

    logic              any_free;
    logic [SLOT_W-1:0] alloc_idx;
    logic              claim;
    logic              rel_in_range;
    logic              rel_is_free;
    logic              rel_ok;
    logic              push_hs;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= StIdle;
            free_q         <= '1;
            free_cnt_q     <= 5'(SLOT_NUM);
            pend_q         <= 1'b0;
            wr_slot_q      <= '0;
            wr_slot_vld_q  <= 1'b0;
            wr_drop_q      <= 1'b0;
            fifo_wr_data_q <= '0;
            err_rel_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            free_q         <= free_d;
            free_cnt_q     <= free_cnt_d;
            pend_q         <= pend_d;
            wr_slot_q      <= wr_slot_d;
            wr_slot_vld_q  <= wr_slot_vld_d;
            wr_drop_q      <= wr_drop_d;
            fifo_wr_data_q <= fifo_wr_data_d;
            err_rel_q      <= err_rel_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        free_d         = free_q;
        pend_d         = pend_q;
        wr_slot_d      = wr_slot_q;
        wr_slot_vld_d  = wr_slot_vld_q;
        wr_drop_d      = 1'b0;
        fifo_wr_data_d = fifo_wr_data_q;
        claim          = 1'b0;
        push_hs        = 1'b0;

        // Scan downwards so the lowest free index wins.
        any_free  = 1'b0;
        alloc_idx = '0;
        for (int i = int'(SLOT_NUM) - 1; i >= 0; i--) begin
            if (free_q[i]) begin
                any_free  = 1'b1;
                alloc_idx = SLOT_W'(i);
            end
        end

        case (state_q)
            StIdle: begin
                if (wr_frame_start || pend_q) begin
                    pend_d = 1'b0;
                    if (any_free) begin
                        claim         = 1'b1;
                        wr_slot_d     = alloc_idx;
                        wr_slot_vld_d = 1'b1;
                        state_d       = StWriting;
                    end else begin
                        wr_drop_d = 1'b1;
                    end
                end
            end
            StWriting: begin
                // A restart keeps the same slot; only completion moves on.
                if (wr_frame_done) begin
                    wr_slot_vld_d  = 1'b0;
                    fifo_wr_data_d = wr_slot_q;
                    state_d        = StPush;
                end
            end
            StPush: begin
                if (wr_frame_start) begin
                    if (pend_q) wr_drop_d = 1'b1;
                    else        pend_d    = 1'b1;
                end
                if (fifo_wr_vld) begin
                    push_hs = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        rel_in_range = ({1'b0, rel_slot} < SlotLim);
        rel_is_free  = 1'b0;
        for (int i = 0; i < int'(SLOT_NUM); i++) begin
            if (rel_slot == SLOT_W'(i)) rel_is_free = free_q[i];
        end
        rel_ok    = rel_en && rel_in_range && !rel_is_free;
        err_rel_d = rel_en && !rel_ok;

        // Claimed and released bits are always distinct, so both updates apply.
        for (int i = 0; i < int'(SLOT_NUM); i++) begin
            if (claim && (alloc_idx == SLOT_W'(i))) free_d[i] = 1'b0;
            if (rel_ok && (rel_slot == SLOT_W'(i))) free_d[i] = 1'b1;
        end

        free_cnt_d = '0;
        for (int i = 0; i < int'(SLOT_NUM); i++) begin
            free_cnt_d = free_cnt_d + 5'(free_d[i]);
        end
    end

    always_comb begin
        fifo_wr_en   = (state_q == StPush);
        fifo_wr_data = fifo_wr_data_q;
        wr_slot      = wr_slot_q;
        wr_slot_vld  = wr_slot_vld_q;
        wr_drop      = wr_drop_q;
        free_cnt     = free_cnt_q;
        err_rel      = err_rel_q;
    end

`ifdef FRAME_SLOT_STAT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [15:0] push_cnt_q, push_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (wr_drop_d && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
        push_cnt_d = push_hs ? push_cnt_q + 16'd1 : push_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            drop_cnt_q <= '0;
            push_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            push_cnt_q <= push_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
    assign push_cnt = push_cnt_q;
`endif

endmodule
